// File: rtl/heap_copy_engine.sv
// Purpose : word-by-word heap mover on heap port B; copy (heap->heap) or fill (constant->heap).
// Latency : copy 2 cycles/word, fill 1 cycle/word, done pulse one cycle after the last write.
// Backpres: none; cmd_start is ignored (not queued) whenever the engine is not idle.
// Ports   : clk/reset_n; cmd_* command (sampled with cmd_start); busy/done/err status;
//           mem_address/mem_wr_data/mem_wr_en drive heap port B, mem_rd_data is its read data
//           (valid one cycle after the address).
module heap_copy_engine #(
  parameter int unsigned CAPACITY_BYTES = 2048,
  parameter int unsigned WORD_BYTES     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_start,
  input  logic        cmd_fill,
  input  logic [31:0] cmd_src,
  input  logic [31:0] cmd_dst,
  input  logic [15:0] cmd_len,
  input  logic [31:0] cmd_value,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_en
);

  if (WORD_BYTES != 4) begin : g_bad_word_bytes
    $error("heap_copy_engine supports WORD_BYTES == 4 only");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [32:0] CAP = 33'(CAPACITY_BYTES);

  state_t      state_q, state_d;
  logic [15:0] i_q, i_d;
  logic [15:0] len_q, len_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] value_q, value_d;
  logic        err_q, err_d;

  // Range check on the word-aligned command addresses, done in 33 bits so
  // that an address near the top of the 32-bit space cannot wrap into range.
  logic [31:0] src_align, dst_align;
  logic [32:0] len_bytes, src_end, dst_end;
  logic        range_bad;

  always_comb begin
    src_align = cmd_src & 32'hFFFF_FFFC;
    dst_align = cmd_dst & 32'hFFFF_FFFC;
    len_bytes = {15'b0, cmd_len, 2'b00};
    src_end   = {1'b0, src_align} + len_bytes;
    dst_end   = {1'b0, dst_align} + len_bytes;
    range_bad = (dst_end > CAP) || (!cmd_fill && (src_end > CAP));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    len_d   = len_q;
    src_d   = src_q;
    dst_d   = dst_q;
    value_d = value_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          src_d   = src_align;
          dst_d   = dst_align;
          len_d   = cmd_len;
          value_d = cmd_value;
          i_d     = '0;
          err_d   = range_bad;
          if (range_bad || (cmd_len == 16'd0)) begin
            state_d = S_DONE;
          end else if (cmd_fill) begin
            state_d = S_FILL;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        state_d = S_WR;
      end
      S_WR: begin
        i_d     = i_q + 16'd1;
        state_d = (i_q == len_q - 16'd1) ? S_DONE : S_RD;
      end
      S_FILL: begin
        i_d     = i_q + 16'd1;
        state_d = (i_q == len_q - 16'd1) ? S_DONE : S_FILL;
      end
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      value_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      len_q   <= len_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      value_q <= value_d;
      err_q   <= err_d;
    end
  end

  // Port drive is a pure decode of registered state, so an asynchronous reset
  // removes the byte enables at once. Only WR write data passes through
  // combinationally from the heap read port.
  logic [31:0] offset;

  always_comb begin
    offset      = {14'b0, i_q, 2'b00};
    mem_address = '0;
    mem_wr_data = '0;
    mem_wr_en   = 4'b0000;
    unique case (state_q)
      S_RD: begin
        mem_address = src_q + offset;
      end
      S_WR: begin
        mem_address = dst_q + offset;
        mem_wr_data = mem_rd_data;
        mem_wr_en   = 4'b1111;
      end
      S_FILL: begin
        mem_address = dst_q + offset;
        mem_wr_data = value_q;
        mem_wr_en   = 4'b1111;
      end
      default: begin
      end
    endcase
  end

  assign busy = (state_q == S_RD) || (state_q == S_WR) || (state_q == S_FILL);
  assign done = (state_q == S_DONE);
  assign err  = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_heap_copy_engine.sv
// Purpose : self-checking bench for heap_copy_engine with a behavioural heap on port B.
// Latency : heap model returns read data one cycle after the address.
// Backpres: none.
module tb_heap_copy_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_start, cmd_fill;
  logic [31:0] cmd_src, cmd_dst, cmd_value;
  logic [15:0] cmd_len;
  logic        busy, done, err;
  logic [31:0] mem_address, mem_rd_data, mem_wr_data;
  logic [3:0]  mem_wr_en;

  always #5 clk = ~clk;

  heap_copy_engine #(.CAPACITY_BYTES(2048), .WORD_BYTES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_fill(cmd_fill), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_value(cmd_value),
    .busy(busy), .done(done), .err(err),
    .mem_address(mem_address), .mem_rd_data(mem_rd_data),
    .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en)
  );

  // Heap model: 512 words, synchronous read, byte-enabled write, preload port.
  logic [31:0] heap [512];
  logic        pre_we;
  logic [31:0] pre_addr, pre_dat;

  always @(posedge clk) begin
    if (pre_we) begin
      heap[pre_addr[10:2]] <= pre_dat;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wr_en[b]) heap[mem_address[10:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
    end
    mem_rd_data <= heap[mem_address[10:2]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_dat  = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  typedef struct {
    logic        fill;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [31:0] value;
    int          done_cyc;
    logic        err;
    int          nwr;
    logic [31:0] first_addr;
    logic [31:0] first_data;
    logic [31:0] last_addr;
    logic [31:0] last_data;
  } vec_t;

  vec_t vecs[9];

  // Issue one command from a negedge and watch it until done (bounded).
  // Returns at the negedge of the cycle after done, when a new start is legal.
  task automatic run_cmd(input vec_t v, output int dc, output logic er, output logic busy_dn,
                         output int nwr, output logic [31:0] fa, output logic [31:0] fd,
                         output logic [31:0] la, output logic [31:0] ld, output logic bad_be);
    dc = 0; er = 1'b0; busy_dn = 1'b0; nwr = 0; bad_be = 1'b0;
    fa = '0; fd = '0; la = '0; ld = '0;
    cmd_fill  = v.fill;
    cmd_src   = v.src;
    cmd_dst   = v.dst;
    cmd_len   = v.len;
    cmd_value = v.value;
    cmd_start = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) cmd_start = 1'b0;
      if (mem_wr_en != 4'h0) begin
        if (mem_wr_en != 4'hF) bad_be = 1'b1;
        if (nwr == 0) begin
          fa = mem_address;
          fd = mem_wr_data;
        end
        la = mem_address;
        ld = mem_wr_data;
        nwr++;
      end
      if (done) begin
        dc      = k;
        er      = err;
        busy_dn = busy;
        break;
      end
    end
    if (dc == 0) $display("FAIL run_cmd: no done within 100 cycles");
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dc, nwr, ndone, first_done;
    logic        er, busy_dn, bad_be;
    logic [31:0] fa, fd, la, ld;
    vec_t        v;

    //          fill  src           dst           len    value          dc er nwr fa          fd            la          ld
    vecs[0] = '{1'b1, 32'h0,        32'h100,      16'd4, 32'hDEADBEEF,  5, 1'b0, 4, 32'h100, 32'hDEADBEEF, 32'h10C, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 32'h0,        32'h200,      16'd3, 32'h0,         7, 1'b0, 3, 32'h200, 32'h11,       32'h208, 32'h33};
    vecs[2] = '{1'b0, 32'h7F8,      32'h0,        16'd3, 32'h0,         1, 1'b1, 0, 32'h0,   32'h0,        32'h0,   32'h0};
    vecs[3] = '{1'b1, 32'h0,        32'h40,       16'd0, 32'h1234,      1, 1'b0, 0, 32'h0,   32'h0,        32'h0,   32'h0};
    vecs[4] = '{1'b1, 32'h0,        32'h103,      16'd1, 32'h5A5A5A5A,  2, 1'b0, 1, 32'h100, 32'h5A5A5A5A, 32'h100, 32'h5A5A5A5A};
    vecs[5] = '{1'b1, 32'h0,        32'h7FC,      16'd1, 32'h1,         2, 1'b0, 1, 32'h7FC, 32'h1,        32'h7FC, 32'h1};
    vecs[6] = '{1'b1, 32'h0,        32'h7FC,      16'd2, 32'h2,         1, 1'b1, 0, 32'h0,   32'h0,        32'h0,   32'h0};
    vecs[7] = '{1'b1, 32'hFFFFFFF0, 32'h0,        16'd1, 32'h7,         2, 1'b0, 1, 32'h0,   32'h7,        32'h0,   32'h7};
    vecs[8] = '{1'b0, 32'h0,        32'hFFFFFFFC, 16'd1, 32'h0,         1, 1'b1, 0, 32'h0,   32'h0,        32'h0,   32'h0};

    reset_n = 1'b0; cmd_start = 1'b0; cmd_fill = 1'b0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_value = '0; pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset err", {31'b0, err}, 32'h0);
    check("reset mem_address", mem_address, 32'h0);
    check("reset mem_wr_data", mem_wr_data, 32'h0);
    check("reset mem_wr_en", {28'b0, mem_wr_en}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    poke(32'h0, 32'h11);
    poke(32'h4, 32'h22);
    poke(32'h8, 32'h33);

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      run_cmd(v, dc, er, busy_dn, nwr, fa, fd, la, ld, bad_be);
      check($sformatf("v%0d done_cycle", i), 32'(dc), 32'(v.done_cyc));
      check($sformatf("v%0d err", i), {31'b0, er}, {31'b0, v.err});
      check($sformatf("v%0d busy_at_done", i), {31'b0, busy_dn}, 32'h0);
      check($sformatf("v%0d write_count", i), 32'(nwr), 32'(v.nwr));
      check($sformatf("v%0d partial_be", i), {31'b0, bad_be}, 32'h0);
      if (v.nwr > 0) begin
        check($sformatf("v%0d first_addr", i), fa, v.first_addr);
        check($sformatf("v%0d first_data", i), fd, v.first_data);
        check($sformatf("v%0d last_addr", i), la, v.last_addr);
        check($sformatf("v%0d last_data", i), ld, v.last_data);
      end
    end

    // Copy destination reads back the source words.
    check("copy readback 0x200", heap[32'h200 >> 2], 32'h11);
    check("copy readback 0x204", heap[32'h204 >> 2], 32'h22);
    check("copy readback 0x208", heap[32'h208 >> 2], 32'h33);

    // Overlapping forward copy, with starts pulsed while busy and during done.
    poke(32'h0, 32'hA);
    poke(32'h4, 32'hB);
    poke(32'h8, 32'hC);
    poke(32'hC, 32'hD);
    poke(32'h300, 32'h0);
    cmd_fill = 1'b0; cmd_src = 32'h0; cmd_dst = 32'h4; cmd_len = 16'd3; cmd_value = 32'h0;
    cmd_start = 1'b1;
    ndone = 0;
    first_done = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = k;
      end
      cmd_start = 1'b0;
      if (k == 2 || k == 7) begin
        cmd_fill = 1'b1; cmd_dst = 32'h300; cmd_len = 16'd1; cmd_value = 32'hBAD;
        cmd_start = 1'b1;
      end
    end
    cmd_start = 1'b0;
    check("overlap done_count", 32'(ndone), 32'd1);
    check("overlap done_cycle", 32'(first_done), 32'd7);
    check("overlap word0", heap[0], 32'hA);
    check("overlap word1", heap[1], 32'hA);
    check("overlap word2", heap[2], 32'hA);
    check("overlap word3", heap[3], 32'hA);
    check("ignored start no write", heap[32'h300 >> 2], 32'h0);

    // Reset in the middle of a fill.
    cmd_fill = 1'b1; cmd_src = 32'h0; cmd_dst = 32'h380; cmd_len = 16'd8; cmd_value = 32'h12345678;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    check("midfill wr_en before reset", {28'b0, mem_wr_en}, 32'hF);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midfill reset wr_en", {28'b0, mem_wr_en}, 32'h0);
    check("midfill reset busy", {31'b0, busy}, 32'h0);
    check("midfill reset address", mem_address, 32'h0);
    ndone = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) ndone++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midfill no done", 32'(ndone), 32'd0);
    check("midfill first word", heap[32'h380 >> 2], 32'h12345678);

    v = '{1'b1, 32'h0, 32'h3F0, 16'd1, 32'h99, 2, 1'b0, 1, 32'h3F0, 32'h99, 32'h3F0, 32'h99};
    run_cmd(v, dc, er, busy_dn, nwr, fa, fd, la, ld, bad_be);
    check("post-reset done_cycle", 32'(dc), 32'd2);
    check("post-reset err", {31'b0, er}, 32'h0);
    check("post-reset write_addr", fa, 32'h3F0);
    check("post-reset mem", heap[32'h3F0 >> 2], 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
